// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the fetch stage: word size, instruction stride and
// the fetch FSM state encodings.
package ifetch_unit_pkg;

    localparam int WORDSIZE   = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE      = 2'd0,
        FETCH_WAIT      = 2'd1,
        FETCH_WAIT_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Small power-of-two FIFO of {pc, instr} pairs feeding decode.
// The head is read straight from registered storage.
module fetch_queue #(
    parameter int WORDSIZE = ifetch_unit_pkg::WORDSIZE,
    parameter int QDEPTH   = 2,
    parameter int CNT_W    = $clog2(QDEPTH) + 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                i_push,
    input  logic [WORDSIZE-1:0] i_push_pc,
    input  logic [WORDSIZE-1:0] i_push_instr,
    input  logic                i_pop,
    input  logic                i_flush,
    output logic [CNT_W-1:0]    o_count,
    output logic [WORDSIZE-1:0] o_head_pc,
    output logic [WORDSIZE-1:0] o_head_instr
);
    localparam int PTR_W = $clog2(QDEPTH);

    logic [WORDSIZE-1:0] r_pc_mem    [QDEPTH];
    logic [WORDSIZE-1:0] r_instr_mem [QDEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because QDEPTH is a power of two.
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (i_push && !i_flush) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    assign o_count      = r_count;
    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: issues one-outstanding imem requests from pc_in, buffers the
// responses for decode and computes the PC register's next value.
//
// state           | meaning
// FETCH_IDLE      | no request outstanding
// FETCH_WAIT      | one request outstanding, response will be queued
// FETCH_WAIT_DROP | one request outstanding, response discarded (redirected)
module ifetch_unit #(
    parameter int                  WORDSIZE = ifetch_unit_pkg::WORDSIZE,
    parameter int                  QDEPTH   = 2,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [WORDSIZE-1:0] pc_in,
    output logic [WORDSIZE-1:0] pc_next,
    input  logic                redirect_valid,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORDSIZE-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [WORDSIZE-1:0] imem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [WORDSIZE-1:0] inst_data,
    output logic [WORDSIZE-1:0] inst_pc
);
    import ifetch_unit_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_t        r_state;
    fetch_state_t        w_state_nx;
    logic [WORDSIZE-1:0] r_req_pc;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_reserved;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    // A slot is held for the outstanding kept response so it can never overflow.
    assign w_reserved = w_count + CNT_W'(r_state == FETCH_WAIT);

    assign imem_req_valid = reset && !redirect_valid
                          && (w_reserved < CNT_W'(QDEPTH))
                          && ((r_state == FETCH_IDLE) || imem_resp_valid);
    assign imem_req_addr  = pc_in;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_push     = (r_state == FETCH_WAIT) && imem_resp_valid && !redirect_valid;
    assign inst_valid = (w_count != '0) && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready;

    always_comb begin
        w_state_nx = r_state;
        if (redirect_valid) begin
            if (r_state != FETCH_IDLE)
                w_state_nx = imem_resp_valid ? FETCH_IDLE : FETCH_WAIT_DROP;
        end else if (w_accept) begin
            w_state_nx = FETCH_WAIT;
        end else if ((r_state != FETCH_IDLE) && imem_resp_valid) begin
            w_state_nx = FETCH_IDLE;
        end
    end

    always_comb begin
        pc_next = pc_in;
        if (!reset)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = redirect_pc;
        else if (w_accept)
            pc_next = pc_in + WORDSIZE'(INST_BYTES);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state  <= FETCH_IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) r_req_pc <= pc_in;
        end
    end

    fetch_queue #(
        .WORDSIZE (WORDSIZE),
        .QDEPTH   (QDEPTH),
        .CNT_W    (CNT_W)
    ) u_fetch_queue (
        .CLK          (CLK),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_resp_data),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_count      (w_count),
        .o_head_pc    (inst_pc),
        .o_head_instr (inst_data)
    );

endmodule
